// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// Latency: done pulses N_BITS edges after start is accepted; minimum period N_BITS+2 cycles.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy.
module bin2bcd_seq #(
  parameter int N_BITS   = 6,
  parameter int N_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_BITS-1:0]     bin,
  input  logic                  neg,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  sign,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  // Scratch holds N_DIGITS result digits plus one guard digit for overflow.
  localparam int SW = 4 * (N_DIGITS + 1);
  localparam int OW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              nz_q, nz_d;
  // Sticky: a set bit was shifted out past the guard digit (only possible
  // when N_BITS is wide enough to exceed the guard digit's range).
  logic              lost_q, lost_d;
  logic [OW-1:0]     bcd_q, bcd_d;
  logic              sign_q, sign_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SW-1:0]     adj;

  // True if any of the low N_DIGITS digits is not a valid decimal digit.
  function automatic logic digits_bad(input logic [SW-1:0] s);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (s[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Add-3 correction: every scratch digit of 5 or more gets +3 before the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < N_DIGITS + 1; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath: capture in IDLE, shift in SHIFT, publish on last shift.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    nz_d      = nz_q;
    lost_d    = lost_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = CW'(N_BITS);
          neg_d     = neg;
          nz_d      = |bin;
          lost_d    = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[SW-2:0], shreg_q[N_BITS-1]};
        lost_d    = lost_q | adj[SW-1];
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          // Negative zero is shown as plain 0.
          sign_d  = neg_q & nz_q;
          if (lost_d || (scratch_d[SW-1 -: 4] != 4'd0) || digits_bad(scratch_d)) begin
            ovf_d = 1'b1;
            bcd_d = {N_DIGITS{4'h9}};
          end else begin
            ovf_d = 1'b0;
            bcd_d = scratch_d[OW-1:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      nz_q      <= 1'b0;
      lost_q    <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      nz_q      <= nz_d;
      lost_q    <= lost_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign sign = sign_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: default 6-bit/2-digit instance plus a 7-bit/2-digit
// instance for overflow, directed boundary cases and random values against a
// decimal arithmetic model.
module tb_bin2bcd_seq;

  logic       clk;
  logic       rst;
  logic       start6, start7;
  logic [5:0] bin6;
  logic [6:0] bin7;
  logic       neg6, neg7;
  logic [7:0] bcd6, bcd7;
  logic       sign6, sign7, ovf6, ovf7, busy6, busy7, done6, done7;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.N_BITS(6), .N_DIGITS(2)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .bin(bin6), .neg(neg6),
    .bcd(bcd6), .sign(sign6), .ovf(ovf6), .busy(busy6), .done(done6)
  );

  bin2bcd_seq #(.N_BITS(7), .N_DIGITS(2)) u_dut7 (
    .clk(clk), .rst(rst), .start(start7), .bin(bin7), .neg(neg7),
    .bcd(bcd7), .sign(sign7), .ovf(ovf7), .busy(busy7), .done(done7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain decimal arithmetic, saturating at 99 for two digits.
  function automatic logic [7:0] model_bcd(input int v);
    if (v > 99) return 8'h99;
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic model_ovf(input int v);
    return (v > 99);
  endfunction

  // Observed outputs of the selected instance.
  function automatic logic [7:0] o_bcd(input int w);  return (w == 6) ? bcd6  : bcd7;  endfunction
  function automatic logic o_sign(input int w);       return (w == 6) ? sign6 : sign7; endfunction
  function automatic logic o_ovf(input int w);        return (w == 6) ? ovf6  : ovf7;  endfunction
  function automatic logic o_busy(input int w);       return (w == 6) ? busy6 : busy7; endfunction
  function automatic logic o_done(input int w);       return (w == 6) ? done6 : done7; endfunction

  task automatic drive(input int w, input logic s, input int v, input logic n);
    if (w == 6) begin
      start6 = s; bin6 = 6'(v); neg6 = n;
    end else begin
      start7 = s; bin7 = 7'(v); neg7 = n;
    end
  endtask

  // Called just after a negedge; leaves the bench just after the negedge
  // following the edge where done falls, so the next call hits E_N+2.
  task automatic conv(input int w, input int v, input logic n);
    int edges;
    bit seen;
    drive(w, 1'b1, v, n);
    @(posedge clk);                           // E0
    @(negedge clk);
    drive(w, 1'b0, $urandom_range(0, 127), $urandom_range(0, 1));
    check("busy_after_start", o_busy(w), 1'b1);
    check("done_low_early", o_done(w), 1'b0);
    edges = 0;
    seen  = 0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (o_done(w)) seen = 1;
    end
    check("done_latency", edges, w);
    check("bcd", o_bcd(w), model_bcd(v));
    check("ovf", o_ovf(w), model_ovf(v));
    check("sign", o_sign(w), n && (v != 0));
    check("busy_in_done", o_busy(w), 1'b1);
    @(posedge clk);                           // E_N+1
    @(negedge clk);
    check("done_one_cycle", o_done(w), 1'b0);
    check("busy_fall", o_busy(w), 1'b0);
    check("bcd_hold", o_bcd(w), model_bcd(v));
  endtask

  initial begin
    int dones;
    rst = 1'b0;
    drive(6, 1'b1, 42, 1'b1);
    drive(7, 1'b1, 127, 1'b1);

    // Reset with start asserted: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_bcd", bcd6, 8'h00);
      check("rst_sign", sign6, 1'b0);
      check("rst_ovf", ovf6, 1'b0);
      check("rst_busy", busy6, 1'b0);
      check("rst_done", done6, 1'b0);
      check("rst_busy7", busy7, 1'b0);
    end
    drive(6, 1'b0, 0, 1'b0);
    drive(7, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", busy6, 1'b0);
    check("idle_bcd", bcd6, 8'h00);

    // Basic and boundary conversions (back to back at minimum period).
    conv(6, 42, 1'b0);
    conv(6, 63, 1'b0);
    conv(6, 0, 1'b1);
    conv(6, 7, 1'b1);

    // Start while busy: second start at E3 is ignored.
    drive(6, 1'b1, 25, 1'b0);
    @(posedge clk);                           // E0
    @(negedge clk);
    drive(6, 1'b0, 25, 1'b0);
    @(posedge clk); @(negedge clk);           // after E1
    @(posedge clk); @(negedge clk);           // after E2
    drive(6, 1'b1, 9, 1'b1);
    @(posedge clk); @(negedge clk);           // after E3
    drive(6, 1'b0, 9, 1'b1);
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); @(negedge clk);
      if (done6) begin
        dones++;
        check("busy_start_bcd", bcd6, 8'h25);
        check("busy_start_sign", sign6, 1'b0);
      end
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_hold", bcd6, 8'h25);
    check("busy_start_idle", busy6, 1'b0);

    // Reset mid-conversion: result lost, no done.
    drive(6, 1'b1, 49, 1'b0);
    @(posedge clk); @(negedge clk);           // after E0
    drive(6, 1'b0, 0, 1'b0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);           // after E2
    rst = 1'b0;
    @(negedge clk);
    check("midrst_bcd", bcd6, 8'h00);
    check("midrst_busy", busy6, 1'b0);
    check("midrst_done", done6, 1'b0);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (done6) dones++;
    end
    check("midrst_no_done", dones, 0);
    conv(6, 49, 1'b0);

    // First edge after reset release accepts start.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    conv(6, 38, 1'b1);

    // Overflow boundaries on the 7-bit instance.
    conv(7, 127, 1'b0);
    conv(7, 99, 1'b0);
    conv(7, 100, 1'b1);
    conv(7, 0, 1'b0);

    // Random values on both widths.
    for (int i = 0; i < 25; i++) begin
      conv(6, $urandom_range(0, 63), 1'($urandom_range(0, 1)));
      conv(7, $urandom_range(0, 127), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
